// File: rtl/uart_rx_frame_ctrl.sv
// Turns the UART byte stream (HDR0 HDR1 LEN payload CSUM) into checked command frames.
// Latency: frame_ok and the first m_valid appear one cycle after the checksum byte; payload drains at 1 byte/cycle.
// Backpressure: m_ready low holds m_data/m_last; bytes arriving while draining are dropped and flagged.
module uart_rx_frame_ctrl #(
  parameter logic [7:0] HDR0        = 8'h55,
  parameter logic [7:0] HDR1        = 8'hAA,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 8680
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic       m_valid,
  output logic [7:0] m_data,
  output logic       m_last,
  input  logic       m_ready,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  // tmo_cnt holds the number of cycles elapsed since the last byte. Acting when
  // it equals TIMEOUT_CYC-2 means the registered error pulse lands on the cycle
  // the count would read TIMEOUT_CYC-1, i.e. TIMEOUT_CYC-1 cycles after the byte.
  localparam logic [CW-1:0] TMO_TERM  = CW'(TIMEOUT_CYC - 2);

  localparam logic [1:0] E_LEN  = 2'b00;
  localparam logic [1:0] E_CSUM = 2'b01;
  localparam logic [1:0] E_TMO  = 2'b10;
  localparam logic [1:0] E_OVR  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_H1, S_LEN, S_PAY, S_CSUM, S_OUT
  } state_t;

  state_t        state, state_nxt;
  logic [7:0]    len, sum, idx, rd;
  logic [CW-1:0] tmo_cnt;
  logic [7:0]    pay_mem [2**AW];

  logic          timed, tmo_fire, len_bad, csum_good, rd_last, xfer;
  logic          ok_nxt, err_nxt;
  logic [1:0]    code_nxt;

  assign timed     = state inside {S_H1, S_LEN, S_PAY, S_CSUM};
  // A byte on the terminal cycle takes priority over the timeout.
  assign tmo_fire  = timed && !rx_done && (tmo_cnt == TMO_TERM);
  assign len_bad   = (rx_data == 8'd0) || (rx_data > MAX_LEN_B);
  assign csum_good = (rx_data == sum);
  assign rd_last   = (rd == (len - 8'd1));
  assign xfer      = (state == S_OUT) && m_ready;

  // State register
  always_ff @(posedge sys_clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode: byte-driven transitions, timeout abort, end of drain
  always_comb begin
    state_nxt = state;
    if (tmo_fire) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (rx_done && rx_data == HDR0) state_nxt = S_H1;
        S_H1: begin
          if (rx_done) begin
            if (rx_data == HDR1)      state_nxt = S_LEN;
            else if (rx_data == HDR0) state_nxt = S_H1;
            else                      state_nxt = S_IDLE;
          end
        end
        S_LEN:  if (rx_done) state_nxt = len_bad ? S_IDLE : S_PAY;
        S_PAY:  if (rx_done && idx == (len - 8'd1)) state_nxt = S_CSUM;
        S_CSUM: if (rx_done) state_nxt = csum_good ? S_OUT : S_IDLE;
        S_OUT:  if (xfer && rd_last) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Output decode: stream outputs from state, next values of the status pulses
  always_comb begin
    ok_nxt   = 1'b0;
    err_nxt  = 1'b0;
    code_nxt = 2'b00;
    busy     = (state != S_IDLE);
    m_valid  = (state == S_OUT);
    m_data   = (state == S_OUT) ? pay_mem[rd[AW-1:0]] : 8'h00;
    m_last   = (state == S_OUT) && rd_last;
    if (tmo_fire) begin
      err_nxt  = 1'b1;
      code_nxt = E_TMO;
    end else if (rx_done) begin
      case (state)
        S_LEN:  if (len_bad) begin err_nxt = 1'b1; code_nxt = E_LEN; end
        S_CSUM: begin
          if (csum_good) ok_nxt = 1'b1;
          else begin err_nxt = 1'b1; code_nxt = E_CSUM; end
        end
        S_OUT:  begin err_nxt = 1'b1; code_nxt = E_OVR; end
        default: ;
      endcase
    end
  end

  // Datapath registers: length, running checksum, indices, timeout, status pulses
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      len       <= 8'd0;
      sum       <= 8'd0;
      idx       <= 8'd0;
      rd        <= 8'd0;
      tmo_cnt   <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 2'b00;
    end else begin
      frame_ok  <= ok_nxt;
      frame_err <= err_nxt;
      err_code  <= code_nxt;
      tmo_cnt   <= rx_done ? CW'(1) : (timed ? tmo_cnt + CW'(1) : '0);
      if (rx_done && state == S_LEN && !len_bad) begin
        len <= rx_data;
        sum <= rx_data;
        idx <= 8'd0;
      end
      if (rx_done && state == S_PAY) begin
        sum <= sum + rx_data;
        idx <= idx + 8'd1;
      end
      if (rx_done && state == S_CSUM) rd <= 8'd0;
      if (xfer) rd <= rd + 8'd1;
    end
  end

  // Payload buffer; contents are don't-care after reset
  always_ff @(posedge sys_clk) begin
    if (rx_done && state == S_PAY) pay_mem[idx[AW-1:0]] <= rx_data;
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: directed frames from the test plan, then randomized frames.
// Expected results come from frame construction (length + payload sum mod 256) and byte-time bookkeeping.
// A negedge monitor logs output events with cycle stamps; the main sequence asserts against them.
module tb_uart_rx_frame_ctrl;

  localparam int         MAX_LEN = 16;
  localparam int         TMO     = 8680;
  localparam logic [7:0] HDR0    = 8'h55;
  localparam logic [7:0] HDR1    = 8'hAA;

  logic       sys_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       m_ready;
  logic       m_valid, m_last, frame_ok, frame_err, busy;
  logic [7:0] m_data;
  logic [1:0] err_code;

  uart_rx_frame_ctrl #(
    .HDR0(HDR0), .HDR1(HDR1), .MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TMO)
  ) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .rx_done(rx_done), .rx_data(rx_data),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code), .busy(busy)
  );

  always #10 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // m_ready source: 0 = always ready, 1 = held low, 2 = random
  int rdy_mode = 0;
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge sys_clk);
      #1;
      case (rdy_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'b0;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Event log
  logic [7:0] out_dat[$];
  logic       out_lst[$];
  int         out_t[$];
  int         ok_t[$];
  logic [1:0] err_c[$];
  int         err_t[$];
  int         mv_cnt = 0, stall_bad = 0, both_bad = 0;
  logic       p_vld = 1'b0, p_rdy = 1'b0, p_last = 1'b0;
  logic [7:0] p_dat = 8'h00;

  always @(negedge sys_clk) begin
    if (rst_n) begin
      if (m_valid) mv_cnt <= mv_cnt + 1;
      if (m_valid && m_ready) begin
        out_dat.push_back(m_data);
        out_lst.push_back(m_last);
        out_t.push_back(cyc);
      end
      if (frame_ok) ok_t.push_back(cyc);
      if (frame_err) begin
        err_c.push_back(err_code);
        err_t.push_back(cyc);
      end
      if (frame_ok && frame_err) both_bad <= both_bad + 1;
      if (p_vld && !p_rdy && !(m_valid === 1'b1 && m_data === p_dat && m_last === p_last))
        stall_bad <= stall_bad + 1;
    end
    p_vld  <= m_valid;
    p_rdy  <= m_ready;
    p_dat  <= m_data;
    p_last <= m_last;
  end

  int checks = 0;
  int errors = 0;
  int t_rx = 0;
  int o0, k0, e0, m0, t0;
  logic [7:0] tx[$];
  logic [7:0] pay[$];
  logic [7:0] cs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // One byte from the receiver, then one idle cycle (minimum rx_done spacing)
  task automatic send(input logic [7:0] b);
    rx_done = 1'b1;
    rx_data = b;
    t_rx    = cyc;
    tick();
    rx_done = 1'b0;
    rx_data = 8'h00;
    tick();
  endtask

  task automatic send_tx();
    foreach (tx[i]) send(tx[i]);
  endtask

  task automatic mark();
    o0 = out_dat.size();
    k0 = ok_t.size();
    e0 = err_c.size();
    m0 = mv_cnt;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(busy), 32'(0));
    tick();
  endtask

  // Reference frame: random payload, checksum = (LEN + sum of payload) mod 256
  task automatic make_pay(input int len);
    int s;
    s = len;
    pay.delete();
    for (int i = 0; i < len; i++) begin
      pay.push_back(8'($urandom_range(0, 255)));
      s += int'(pay[i]);
    end
    cs = 8'(s % 256);
  endtask

  // corrupt: 0 clean, 1 one payload byte altered, 2 checksum altered
  task automatic send_body(input int corrupt);
    int j;
    logic [7:0] d;
    j = $urandom_range(0, pay.size() - 1);
    d = 8'($urandom_range(1, 255));
    send(HDR0);
    send(HDR1);
    send(8'(pay.size()));
    for (int i = 0; i < pay.size(); i++)
      send((corrupt == 1 && i == j) ? 8'(pay[i] + d) : pay[i]);
    send((corrupt == 2) ? 8'(cs + d) : cs);
  endtask

  // kind: 0 bad LEN, 1 corrupted payload, 2 corrupted checksum, 3 good
  task automatic frame(input int k, input int kind);
    int len;
    bit good;
    mark();
    if (kind == 0) begin
      len = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(MAX_LEN + 1, 255));
      send(HDR0);
      send(HDR1);
      send(8'(len));
      tick();
      check($sformatf("f%0d_badlen_nerr", k), 32'(err_c.size() - e0), 32'(1));
      check($sformatf("f%0d_badlen_code", k), 32'(err_c[e0]), 32'(2'b00));
      check($sformatf("f%0d_badlen_nok", k), 32'(ok_t.size() - k0), 32'(0));
    end else begin
      len = $urandom_range(1, MAX_LEN);
      make_pay(len);
      send_body((kind == 1) ? 1 : (kind == 2) ? 2 : 0);
      wait_idle($sformatf("f%0d_idle", k), 600);
      good = (kind >= 3);
      check($sformatf("f%0d_nok", k), 32'(ok_t.size() - k0), good ? 32'(1) : 32'(0));
      check($sformatf("f%0d_nerr", k), 32'(err_c.size() - e0), good ? 32'(0) : 32'(1));
      if (!good) check($sformatf("f%0d_code", k), 32'(err_c[e0]), 32'(2'b01));
      check($sformatf("f%0d_nout", k), 32'(out_dat.size() - o0), good ? 32'(len) : 32'(0));
      if (good) begin
        for (int i = 0; i < len; i++) begin
          check($sformatf("f%0d_dat%0d", k, i), 32'(out_dat[o0 + i]), 32'(pay[i]));
          check($sformatf("f%0d_last%0d", k, i), 32'(out_lst[o0 + i]), 32'(i == len - 1));
        end
      end
    end
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    tick(); tick(); tick();
    check("reset_outs", 32'({m_valid, m_data, m_last, frame_ok, frame_err, err_code, busy}), 32'(0));
    rst_n = 1'b1;
    tick();

    // Good frame, m_ready high
    mark();
    tx = '{8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    send_tx();
    t0 = t_rx;
    wait_idle("good_idle", 50);
    check("good_nok", 32'(ok_t.size() - k0), 32'(1));
    check("good_ok_time", 32'(ok_t[k0]), 32'(t0 + 1));
    check("good_nerr", 32'(err_c.size() - e0), 32'(0));
    check("good_nout", 32'(out_dat.size() - o0), 32'(3));
    tx = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 3; i++) begin
      check($sformatf("good_dat%0d", i), 32'(out_dat[o0 + i]), 32'(tx[i]));
      check($sformatf("good_last%0d", i), 32'(out_lst[o0 + i]), 32'(i == 2));
      check($sformatf("good_time%0d", i), 32'(out_t[o0 + i]), 32'(t0 + 1 + i));
    end

    // Corrupted payload byte
    mark();
    tx = '{8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h34, 8'h69};
    send_tx();
    t0 = t_rx;
    wait_idle("csum_idle", 10);
    check("csum_nerr", 32'(err_c.size() - e0), 32'(1));
    check("csum_code", 32'(err_c[e0]), 32'(2'b01));
    check("csum_time", 32'(err_t[e0]), 32'(t0 + 1));
    check("csum_no_valid", 32'(mv_cnt - m0), 32'(0));
    check("csum_nok", 32'(ok_t.size() - k0), 32'(0));

    // LEN = 0 and LEN = MAX_LEN+1, then a good frame
    mark();
    tx = '{8'h55, 8'hAA, 8'h00};
    send_tx();
    check("len0_code", 32'(err_c[e0]), 32'(2'b00));
    check("len0_time", 32'(err_t[e0]), 32'(t_rx + 1));
    tx = '{8'h55, 8'hAA, 8'(MAX_LEN + 1)};
    send_tx();
    check("lenmax_nerr", 32'(err_c.size() - e0), 32'(2));
    check("lenmax_code", 32'(err_c[e0 + 1]), 32'(2'b00));
    check("len_busy", 32'(busy), 32'(0));
    frame(100, 3);

    // Header resync
    mark();
    tx = '{8'h55, 8'h55, 8'hAA, 8'h01, 8'h7F, 8'h80};
    send_tx();
    wait_idle("resync_idle", 20);
    check("resync_nok", 32'(ok_t.size() - k0), 32'(1));
    check("resync_nout", 32'(out_dat.size() - o0), 32'(1));
    check("resync_dat", 32'(out_dat[o0]), 32'(8'h7F));
    check("resync_last", 32'(out_lst[o0]), 32'(1));

    // Inter-byte timeout
    mark();
    tx = '{8'h55, 8'hAA, 8'h02, 8'h10};
    send_tx();
    t0 = t_rx;
    for (int n = 0; n < TMO + 20 && err_c.size() == e0; n++) tick();
    check("tmo_nerr", 32'(err_c.size() - e0), 32'(1));
    check("tmo_code", 32'(err_c[e0]), 32'(2'b10));
    check("tmo_time", 32'(err_t[e0]), 32'(t0 + TMO - 1));
    check("tmo_busy", 32'(busy), 32'(0));

    // Byte on the terminal-count cycle keeps the frame alive
    mark();
    send_tx();
    t0 = t_rx;
    while (cyc < t0 + TMO - 2) tick();
    send(8'h20);
    check("tmo_edge_rx_cyc", 32'(t_rx), 32'(t0 + TMO - 2));
    send(8'h32);
    wait_idle("tmo_edge_idle", 20);
    check("tmo_edge_nerr", 32'(err_c.size() - e0), 32'(0));
    check("tmo_edge_nok", 32'(ok_t.size() - k0), 32'(1));
    check("tmo_edge_nout", 32'(out_dat.size() - o0), 32'(2));
    check("tmo_edge_dat1", 32'(out_dat[o0 + 1]), 32'(8'h20));

    // Stall with m_ready low, overrun byte while draining
    rdy_mode = 1;
    tick(); tick();
    mark();
    make_pay(4);
    send_body(0);
    t0 = t_rx;
    for (int i = 0; i < 4; i++) tick();
    check("stall_vld", 32'(m_valid), 32'(1));
    check("stall_dat", 32'(m_data), 32'(pay[0]));
    check("stall_last", 32'(m_last), 32'(0));
    check("stall_nok", 32'(ok_t.size() - k0), 32'(1));
    send(8'h55);
    check("ovr_nerr", 32'(err_c.size() - e0), 32'(1));
    check("ovr_code", 32'(err_c[e0]), 32'(2'b11));
    check("ovr_time", 32'(err_t[e0]), 32'(t_rx + 1));
    for (int i = 0; i < 12; i++) tick();
    check("ovr_vld", 32'(m_valid), 32'(1));
    check("ovr_dat", 32'(m_data), 32'(pay[0]));
    check("stall_nout", 32'(out_dat.size() - o0), 32'(0));
    check("stall_hold", 32'(stall_bad), 32'(0));
    rdy_mode = 0;
    wait_idle("ovr_idle", 50);
    check("ovr_nout", 32'(out_dat.size() - o0), 32'(4));
    for (int i = 0; i < 4; i++)
      check($sformatf("ovr_dat%0d", i), 32'(out_dat[o0 + i]), 32'(pay[i]));
    check("ovr_nerr_end", 32'(err_c.size() - e0), 32'(1));
    check("ovr_nok_end", 32'(ok_t.size() - k0), 32'(1));

    // Reset in the middle of the payload
    mark();
    tx = '{8'h55, 8'hAA, 8'h05, 8'h01, 8'h02};
    send_tx();
    check("pre_rst_busy", 32'(busy), 32'(1));
    rst_n = 1'b0;
    tick();
    check("rst_mid_outs", 32'({m_valid, m_data, m_last, frame_ok, frame_err, err_code, busy}), 32'(0));
    rst_n = 1'b1;
    tick();
    check("rst_mid_nerr", 32'(err_c.size() - e0), 32'(0));
    check("rst_mid_nok", 32'(ok_t.size() - k0), 32'(0));
    frame(200, 3);

    // Randomized frames with random backpressure
    rdy_mode = 2;
    for (int k = 0; k < 30; k++) begin
      int r;
      r = $urandom_range(0, 7);
      frame(k, (r > 3) ? 3 : r);
    end
    rdy_mode = 0;
    tick();

    check("stall_stable_all", 32'(stall_bad), 32'(0));
    check("ok_err_exclusive", 32'(both_bad), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
